// File: rtl/key_pkg.sv
// Shared definitions for the key/switch event unit: event record layout,
// CPU register addresses and the default debounce length.
package key_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;  // 5 ms at 50 MHz
    localparam int ADDR_EVENT              = 996;
    localparam int ADDR_STATUS             = 997;

    typedef struct packed {
        logic       level;  // new debounced level of the switch
        logic [3:0] zero;
        logic [2:0] index;  // which switch changed
    } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// One switch bit: 2-flop synchronizer, disagreement counter and stable flop.
// changed strobes on the cycle the stable level flips.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable,
    output logic changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The level is accepted once it has disagreed for DEBOUNCE_CYCLES cycles.
    assign changed = (sync2 != sw_stable) && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            sw_stable <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync2 == sw_stable) begin
                cnt <= '0;
            end else if (changed) begin
                cnt       <= '0;
                sw_stable <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_event_unit.sv
// Eight debounced switches feeding a small event FIFO read by the CPU,
// with a key interrupt per queued event and a sticky overflow flag.
module key_event_unit
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw_raw,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] event_data,
    output logic [7:0] status,
    output logic [7:0] sw_stable,
    output logic       key_int
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

    logic [7:0]      changed;
    logic [7:0]      pending;
    logic [7:0]      clr_mask;
    logic            pick_valid;
    logic [2:0]      pick_idx;
    key_event_t      push_ev;
    key_event_t      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            ovf;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk       (clk),
            .reset     (reset),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .changed   (changed[i])
        );
    end

    // Lowest-index pending bit wins; its level is read at push time so a
    // bounce-back while waiting reports the final stable level.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                pick_valid = 1'b1;
                pick_idx   = 3'(i);
            end
        end
        push_ev.level = sw_stable[pick_idx];
        push_ev.zero  = 4'b0;
        push_ev.index = pick_idx;
        clr_mask      = pick_valid ? (8'b1 << pick_idx) : 8'h00;
    end

    // Handshake: key_int is a one-cycle strobe per event that entered the FIFO;
    // rd_en pops the head at the end of its cycle and is ignored when empty.
    assign full    = (count == FULL_COUNT);
    assign pop     = rd_en && (count != '0);
    assign push_ok = pick_valid && (!full || pop);
    assign drop    = pick_valid && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 8'h00;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            key_int <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | changed;
            key_int <= push_ok;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + CNTW'(1);
            else if (pop && !push_ok) count <= count - CNTW'(1);
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    // Storage is not reset; empty reads are masked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_ev;
    end

    assign event_data = (count == '0) ? 8'h00 : mem[rd_ptr];
    assign status     = {ovf, 4'b0, 3'(count)};

endmodule
